// File: rtl/cfa_raster_addr_gen_if.sv
// ---------------------------------------------------------------------------
// cfa_raster_addr_gen_if
//   Bundle between a frame controller and the CFA raster address generator.
//   master : frame controller (drives start/en/window config, observes walk)
//   slave  : address generator (consumes config, presents pixel addresses)
//   Signals:
//     start, en                  launch / pixel stall
//     rowMax, colMax             inclusive window extents
//     baseAddr, rowStride        pixel (0,0) address and line pitch
//     patternSelect, quadMode    CFA layout selection
//     address, addressValid      current pixel address and its qualifier
//     ready, done                idle indication / end-of-frame pulse
//     bufferEnable               line buffers primed, pixel may be consumed
//     rowUpdateFlag, colUpdateFlag  first / last pixel of a row
//     row, col, bayerSymbol      current position and its colour
// ---------------------------------------------------------------------------
interface cfa_raster_addr_gen_if #(
   parameter int ROW_W  = 11,
   parameter int COL_W  = 11,
   parameter int ADDR_W = 22
);
   logic              start;
   logic              en;
   logic [ROW_W-1:0]  rowMax;
   logic [COL_W-1:0]  colMax;
   logic [ADDR_W-1:0] baseAddr;
   logic [ADDR_W-1:0] rowStride;
   logic [1:0]        patternSelect;
   logic              quadMode;
   logic [ADDR_W-1:0] address;
   logic              addressValid;
   logic              ready;
   logic              done;
   logic              bufferEnable;
   logic              rowUpdateFlag;
   logic              colUpdateFlag;
   logic [ROW_W-1:0]  row;
   logic [COL_W-1:0]  col;
   logic [1:0]        bayerSymbol;

   modport master (
      output start, en, rowMax, colMax, baseAddr, rowStride, patternSelect, quadMode,
      input  address, addressValid, ready, done, bufferEnable,
             rowUpdateFlag, colUpdateFlag, row, col, bayerSymbol
   );

   modport slave (
      input  start, en, rowMax, colMax, baseAddr, rowStride, patternSelect, quadMode,
      output address, addressValid, ready, done, bufferEnable,
             rowUpdateFlag, colUpdateFlag, row, col, bayerSymbol
   );
endinterface

// File: rtl/cfa_raster_addr_gen.sv
// ---------------------------------------------------------------------------
// cfa_raster_addr_gen
//   Raster address generator for a CFA (Bayer) frame buffer. Walks a
//   (rowMax+1) x (colMax+1) window starting at baseAddr with a line pitch of
//   rowStride, presenting one pixel address per accepted cycle together with
//   row/col, row-boundary flags and the CFA colour symbol.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   cfa_raster_addr_gen_if.slave (config in, pixel stream out)
//   Optional feature: define CFA_QUAD_EN to enable the quad-Bayer symbol
//   layout (2x2-pixel colour blocks) selected by quadMode at frame start.
// ---------------------------------------------------------------------------
module cfa_raster_addr_gen #(
   parameter int ROW_W      = 11,
   parameter int COL_W      = 11,
   parameter int ADDR_W     = 22,
   parameter int PRIME_ROWS = 2
) (
   input logic                    clk,
   input logic                    rst,
   cfa_raster_addr_gen_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] row_start_q, row_start_d;
   logic [ROW_W-1:0]  row_max_q, row_max_d;
   logic [COL_W-1:0]  col_max_q, col_max_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [1:0]        pat_q, pat_d;
   logic [1:0]        phase;
`ifdef CFA_QUAD_EN
   logic              quad_q, quad_d;
`else
   logic              unused_quad;
   assign unused_quad = bus.quadMode;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         row_q       <= '0;
         col_q       <= '0;
         addr_q      <= '0;
         row_start_q <= '0;
         row_max_q   <= '0;
         col_max_q   <= '0;
         stride_q    <= '0;
         pat_q       <= '0;
`ifdef CFA_QUAD_EN
         quad_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         addr_q      <= addr_d;
         row_start_q <= row_start_d;
         row_max_q   <= row_max_d;
         col_max_q   <= col_max_d;
         stride_q    <= stride_d;
         pat_q       <= pat_d;
`ifdef CFA_QUAD_EN
         quad_q      <= quad_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      addr_d      = addr_q;
      row_start_d = row_start_q;
      row_max_d   = row_max_q;
      col_max_d   = col_max_q;
      stride_d    = stride_q;
      pat_d       = pat_q;
`ifdef CFA_QUAD_EN
      quad_d      = quad_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               row_max_d   = bus.rowMax;
               col_max_d   = bus.colMax;
               stride_d    = bus.rowStride;
               pat_d       = bus.patternSelect;
`ifdef CFA_QUAD_EN
               quad_d      = bus.quadMode;
`endif
               row_d       = '0;
               col_d       = '0;
               addr_d      = bus.baseAddr;
               row_start_d = bus.baseAddr;
               state_d     = RUN;
            end
         end
         RUN: begin
            if (bus.en) begin
               if (col_q != col_max_q) begin
                  col_d  = col_q + COL_W'(1);
                  addr_d = addr_q + ADDR_W'(1);
               end else if (row_q != row_max_q) begin
                  // Next line start is tracked separately so padded pitches
                  // never need a multiply.
                  col_d       = '0;
                  row_d       = row_q + ROW_W'(1);
                  row_start_d = row_start_q + stride_q;
                  addr_d      = row_start_q + stride_q;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef CFA_QUAD_EN
   assign phase = quad_q ? {row_q[1], col_q[1]} : {row_q[0], col_q[0]};
`else
   assign phase = {row_q[0], col_q[0]};
`endif

   // Stall is zero-latency: en gates the valid combinationally.
   assign bus.addressValid  = (state_q == RUN) && bus.en;
   assign bus.ready         = (state_q == IDLE);
   assign bus.done          = (state_q == DONE);
   assign bus.address       = addr_q;
   assign bus.row           = row_q;
   assign bus.col           = col_q;
   assign bus.bufferEnable  = bus.addressValid && (row_q >= ROW_W'(PRIME_ROWS));
   assign bus.rowUpdateFlag = bus.addressValid && (col_q == '0);
   assign bus.colUpdateFlag = bus.addressValid && (col_q == col_max_q);
   assign bus.bayerSymbol   = pat_q ^ phase;

endmodule

// File: tb/tb_cfa_raster_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_cfa_raster_addr_gen
//   Directed bench for cfa_raster_addr_gen: full frames, stalls, padded
//   strides, address wrap, mid-frame reset, back-to-back starts and the CFA
//   symbol layout (quad-Bayer when CFA_QUAD_EN is defined).
// ---------------------------------------------------------------------------
module tb_cfa_raster_addr_gen;

   logic clk;
   logic rst;
   int   passed = 0;
   int   total  = 0;

   cfa_raster_addr_gen_if #(.ROW_W(11), .COL_W(11), .ADDR_W(22)) bus ();

   cfa_raster_addr_gen #(
      .ROW_W(11), .COL_W(11), .ADDR_W(22), .PRIME_ROWS(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [1:0] exp_sym(input logic [1:0] p, input int r, input int c, input bit q);
      bit qe;
`ifdef CFA_QUAD_EN
      qe = q;
`else
      qe = 1'b0;
`endif
      return qe ? (p ^ {r[1], c[1]}) : (p ^ {r[0], c[0]});
   endfunction

   // Runs one frame from IDLE and checks every accepted pixel against the
   // raster position; toggle=1 stalls every other cycle.
   task automatic frame(input int rmax, input int cmax, input logic [21:0] base,
                        input logic [21:0] stride, input logic [1:0] pat,
                        input bit quad, input bit toggle, input string nm);
      int r, c, n, npix;
      bit e;
      logic [21:0] ea;
      @(negedge clk);
      #1;
      chk({nm, "_ready_idle"}, bus.ready, 1);
      bus.rowMax = 11'(rmax); bus.colMax = 11'(cmax);
      bus.baseAddr = base; bus.rowStride = stride;
      bus.patternSelect = pat; bus.quadMode = quad;
      bus.start = 1'b1; bus.en = 1'b1;
      r = 0; c = 0; n = 0; npix = (rmax + 1) * (cmax + 1);
      for (int cyc = 0; cyc < 400 && n < npix; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0;
         e = toggle ? (cyc % 2 == 0) : 1'b1;
         bus.en = e;
         #1;
         chk($sformatf("%s_valid_c%0d", nm, cyc), bus.addressValid, e);
         if (e) begin
            ea = 22'(base + r * stride + c);
            chk($sformatf("%s_addr_p%0d", nm, n), bus.address, ea);
            chk($sformatf("%s_row_p%0d", nm, n), bus.row, r);
            chk($sformatf("%s_col_p%0d", nm, n), bus.col, c);
            chk($sformatf("%s_sym_p%0d", nm, n), bus.bayerSymbol, exp_sym(pat, r, c, quad));
            chk($sformatf("%s_rowupd_p%0d", nm, n), bus.rowUpdateFlag, c == 0);
            chk($sformatf("%s_colupd_p%0d", nm, n), bus.colUpdateFlag, c == cmax);
            chk($sformatf("%s_bufen_p%0d", nm, n), bus.bufferEnable, r >= 2);
            n++;
            if (c == cmax) begin c = 0; r++; end else c++;
         end
      end
      chk({nm, "_pixel_count"}, n, npix);
      bus.en = 1'b1;
      @(negedge clk);
      #1;
      chk({nm, "_done"}, bus.done, 1);
      chk({nm, "_done_valid"}, bus.addressValid, 0);
      chk({nm, "_done_ready"}, bus.ready, 0);
      @(negedge clk);
      #1;
      chk({nm, "_after_done"}, bus.done, 0);
      chk({nm, "_after_ready"}, bus.ready, 1);
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.en = 1'b0;
      bus.rowMax = '0; bus.colMax = '0; bus.baseAddr = '0; bus.rowStride = '0;
      bus.patternSelect = '0; bus.quadMode = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_ready", bus.ready, 1);
      chk("rst_valid", bus.addressValid, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_addr", bus.address, 0);
      chk("rst_row", bus.row, 0);
      chk("rst_col", bus.col, 0);
      chk("rst_sym", bus.bayerSymbol, 0);
      chk("rst_flags", {bus.bufferEnable, bus.rowUpdateFlag, bus.colUpdateFlag}, 0);
      rst = 1'b0;

      // T1: 8x8, BGGR, no stall
      frame(7, 7, 22'd0, 22'd8, 2'b11, 1'b0, 1'b0, "t1");
      // T2: same, stall every other cycle
      frame(7, 7, 22'd0, 22'd8, 2'b11, 1'b0, 1'b1, "t2");
      // T3: 4x4 window in a 16-wide padded buffer
      frame(3, 3, 22'h100, 22'd16, 2'b01, 1'b0, 1'b0, "t3");
      // T4: single pixel at top of memory, then wrap to zero
      frame(0, 0, 22'h3FFFFF, 22'd1, 2'b10, 1'b0, 1'b0, "t4a");
      frame(0, 1, 22'h3FFFFF, 22'd1, 2'b10, 1'b0, 1'b0, "t4b");

      // T5: reset after pixel 20 is accepted
      @(negedge clk);
      bus.rowMax = 11'd7; bus.colMax = 11'd7; bus.baseAddr = 22'd0;
      bus.rowStride = 22'd8; bus.patternSelect = 2'b11; bus.quadMode = 1'b0;
      bus.start = 1'b1; bus.en = 1'b1;
      for (int k = 0; k < 21; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      #1;
      chk("t5_pix20_addr", bus.address, 20);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t5_ready", bus.ready, 1);
      chk("t5_valid", bus.addressValid, 0);
      chk("t5_row", bus.row, 0);
      chk("t5_col", bus.col, 0);
      chk("t5_addr", bus.address, 0);
      chk("t5_no_done", bus.done, 0);
      @(negedge clk);
      #1;
      chk("t5_no_done_later", bus.done, 0);
      frame(7, 7, 22'h40, 22'd8, 2'b11, 1'b0, 1'b0, "t5r");

      // T5b: start held high relaunches with one ready cycle between frames
      @(negedge clk);
      bus.rowMax = 11'd1; bus.colMax = 11'd1; bus.baseAddr = 22'h200;
      bus.rowStride = 22'd4; bus.patternSelect = 2'b00;
      bus.start = 1'b1; bus.en = 1'b1;
      @(negedge clk); #1;
      chk("t5b_p0", bus.address, 22'h200);
      @(negedge clk); #1;
      chk("t5b_p1", bus.address, 22'h201);
      @(negedge clk); #1;
      chk("t5b_p2", bus.address, 22'h204);
      @(negedge clk); #1;
      chk("t5b_p3", bus.address, 22'h205);
      @(negedge clk); #1;
      chk("t5b_done", bus.done, 1);
      @(negedge clk); #1;
      chk("t5b_gap_ready", bus.ready, 1);
      chk("t5b_gap_valid", bus.addressValid, 0);
      @(negedge clk); #1;
      chk("t5b_relaunch_valid", bus.addressValid, 1);
      chk("t5b_relaunch_addr", bus.address, 22'h200);
      bus.start = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      chk("t5b_final_ready", bus.ready, 1);

      // T6: quad-Bayer layout (plain 2x2 when the feature is compiled out)
      frame(7, 7, 22'd0, 22'd8, 2'b00, 1'b1, 1'b0, "t6");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
